// File: rtl/bin2bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_pkg
// Shared constants, FSM state type and the leading-zero blank helper for the
// bin2bcd_disp write-back display converter.
// -----------------------------------------------------------------------------
package bin2bcd_pkg;

  localparam int DATA_W     = 32;  // binary input width (design is fixed at 32)
  localparam int DIGITS     = 8;   // BCD digits driven to the displays
  localparam int ACC_DIGITS = 10;  // accumulator digits: 8 shown + 2 overflow
  localparam int CNT_W      = 6;   // shift counter width

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  // Bit i (i >= 1) is set when digits i..DIGITS-1 are all zero. Bit 0 stays
  // clear so a value of zero still shows a single "0".
  function automatic logic [DIGITS-1:0] blank_mask(input logic [4*DIGITS-1:0] bcd);
    logic [DIGITS-1:0] mask;
    logic              all_zero;
    // NOTE: function locals are plain variables evaluated in order, so blocking
    // assignments are correct here; registered state always uses <=.
    mask     = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (bcd[4*i +: 4] == 4'd0);
      mask[i]  = all_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bin2bcd_disp_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more, so
// the following left shift carries correctly into the next digit.
//   digit_i  in  4  accumulator digit before the shift
//   digit_o  out 4  corrected digit
// -----------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Digits never exceed 9 between shifts, so the sum stays within 4 bits.
  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_disp.sv
// -----------------------------------------------------------------------------
// bin2bcd_disp
// Sequential double-dabble converter from the 32-bit core write-back value to
// eight packed BCD digits for the 7-segment decoders. One shift per clock;
// the last result, its leading-zero blank mask and an overflow flag are held
// in registers between conversions.
//   clk_i    in  1   divided core clock
//   rst_i    in  1   asynchronous active-high reset
//   data_i   in  32  binary value from write-back
//   valid_i  in  1   data_i valid this cycle
//   ready_o  out 1   idle, next valid_i is accepted
//   bcd_o    out 32  packed BCD digits, digit 0 in [3:0]
//   blank_o  out 8   bit i set: digit i is a leading zero
//   ovf_o    out 1   last accepted value exceeded 99_999_999
//   done_o   out 1   one-cycle pulse when bcd_o/blank_o/ovf_o update
// -----------------------------------------------------------------------------
module bin2bcd_disp
  import bin2bcd_pkg::*;
#(
  parameter logic [3:0] OVF_FILL = 4'hF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic [DIGITS-1:0]   blank_o,
  output logic                ovf_o,
  output logic                done_o
);

  localparam int ACC_W = 4 * ACC_DIGITS;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  bin_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               acc_ovf;

  // Correction is applied to all ten digits, overflow digits included.
  for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  // Anything in the two extra digits means the value does not fit in eight.
  assign acc_ovf = |acc_q[ACC_W-1 : 4*DIGITS];
  assign ready_o = (state_q == IDLE);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: if (valid_i) state_d = CONV;
      CONV: if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_o   <= '0;
      blank_o <= 8'hFE;
      ovf_o   <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_o  <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            bin_q <= data_i;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        CONV: begin
          // Shift the corrected accumulator and the binary register as one word.
          {acc_q, bin_q} <= {acc_adj[ACC_W-2:0], bin_q, 1'b0};
          cnt_q          <= cnt_q + 1'b1;
        end
        DONE: begin
          if (acc_ovf) begin
            ovf_o   <= 1'b1;
            bcd_o   <= {DIGITS{OVF_FILL}};
            blank_o <= '0;
          end else begin
            ovf_o   <= 1'b0;
            bcd_o   <= acc_q[4*DIGITS-1:0];
            blank_o <= blank_mask(acc_q[4*DIGITS-1:0]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_disp.sv
module tb_bin2bcd_disp;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] bcd_o;
  logic [7:0]  blank_o;
  logic        ovf_o;
  logic        done_o;

  int n_checks = 0;
  int n_pass   = 0;

  bin2bcd_disp dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .bcd_o   (bcd_o),
    .blank_o (blank_o),
    .ovf_o   (ovf_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Accept one value with a single-cycle valid pulse, then wait for done_o.
  // Optionally pulse a spurious valid with other data during the conversion.
  task automatic convert(input string tag, input logic [31:0] d,
                         input logic [31:0] exp_bcd, input logic [7:0] exp_blank,
                         input logic exp_ovf, input bit spurious);
    int edges;
    int ready_low;
    @(negedge clk_i);
    check({tag, "_ready_before"}, 32'(ready_o), 32'd1);
    data_i  = d;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i   = 1'b0;
    edges     = 0;
    ready_low = 0;
    while (!done_o && edges < 100) begin
      if (!ready_o) ready_low++;
      if (spurious && edges == 5) begin
        data_i  = 32'd7;
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      @(negedge clk_i);
      edges++;
    end
    valid_i = 1'b0;
    check({tag, "_done_seen"}, 32'(done_o), 32'd1);
    check({tag, "_latency"}, 32'(edges), 32'd33);
    check({tag, "_ready_low"}, 32'(ready_low), 32'd33);
    check({tag, "_bcd"}, bcd_o, exp_bcd);
    check({tag, "_blank"}, 32'(blank_o), 32'(exp_blank));
    check({tag, "_ovf"}, 32'(ovf_o), 32'(exp_ovf));
    check({tag, "_ready_at_done"}, 32'(ready_o), 32'd1);
    @(negedge clk_i);
    check({tag, "_done_pulse_1cyc"}, 32'(done_o), 32'd0);
    check({tag, "_bcd_hold"}, bcd_o, exp_bcd);
  endtask

  initial begin
    int pulses;
    int last_edge;
    int edge_cnt;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    #12;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_bcd", bcd_o, 32'h0);
    check("rst_blank", 32'(blank_o), 32'h0000_00FE);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    convert("zero", 32'd0, 32'h0000_0000, 8'hFE, 1'b0, 1'b0);
    convert("v12345678", 32'd12_345_678, 32'h1234_5678, 8'h00, 1'b0, 1'b0);
    convert("v99999999", 32'd99_999_999, 32'h9999_9999, 8'h00, 1'b0, 1'b0);
    convert("v100000000", 32'd100_000_000, 32'hFFFF_FFFF, 8'h00, 1'b1, 1'b0);
    convert("v305_spur", 32'd305, 32'h0000_0305, 8'hF8, 1'b0, 1'b1);

    // No second done pulse from the ignored mid-conversion valid.
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o) pulses++;
    end
    check("v305_extra_done", 32'(pulses), 32'd0);
    check("v305_bcd_still", bcd_o, 32'h0000_0305);

    // Abort a conversion of 42 with an asynchronous mid-cycle reset.
    @(negedge clk_i);
    data_i  = 32'd42;
    valid_i = 1'b1;
    @(negedge clk_i);   // accept edge N has passed, counter = 0
    valid_i = 1'b0;
    repeat (10) @(negedge clk_i);  // counter = 10
    #2 rst_i = 1'b1;
    #1;
    check("abort_bcd", bcd_o, 32'h0);
    check("abort_blank", 32'(blank_o), 32'h0000_00FE);
    check("abort_ovf", 32'(ovf_o), 32'd0);
    check("abort_ready", 32'(ready_o), 32'd1);
    check("abort_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    rst_i  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    convert("v42", 32'd42, 32'h0000_0042, 8'hFC, 1'b0, 1'b0);

    // valid_i held high: repeated overflow conversions every 34 cycles.
    @(negedge clk_i);
    data_i    = 32'hFFFF_FFFF;
    valid_i   = 1'b1;
    pulses    = 0;
    last_edge = -1;
    edge_cnt  = 0;
    while (pulses < 3 && edge_cnt < 200) begin
      @(negedge clk_i);
      edge_cnt++;
      if (done_o) begin
        pulses++;
        check("b2b_ovf", 32'(ovf_o), 32'd1);
        check("b2b_bcd", bcd_o, 32'hFFFF_FFFF);
        check("b2b_blank", 32'(blank_o), 32'h0);
        if (last_edge >= 0) check("b2b_period", 32'(edge_cnt - last_edge), 32'd34);
        last_edge = edge_cnt;
      end
    end
    check("b2b_pulses", 32'(pulses), 32'd3);
    valid_i = 1'b0;
    repeat (40) @(negedge clk_i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
